// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing, pixel-memory addressing and
// latency-matched sync/blank/colour output pipeline.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 1,
  parameter int COLOR_W  = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 scale,
  output logic [9:0]           h_addr,
  output logic [9:0]           v_addr,
  output logic                 rd_en,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 valid,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);

  if (RD_LAT < 0 || RD_LAT > 4 ||
      H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_param_err
    $error("vga_scan_ctrl: illegal parameter set");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic [31:0]   hx;
  logic [31:0]   vx;
  logic [31:0]   hx_s;
  logic [31:0]   vx_s;
  logic          scale_q;
  logic          act0;
  logic          hs0;
  logic          vs0;

  logic [RD_LAT:0] hs_p;
  logic [RD_LAT:0] vs_p;
  logic [RD_LAT:0] act_p;
  logic            act_mem;

  assign hx     = 32'(h_cnt);
  assign vx     = 32'(v_cnt);
  assign h_last = (hx == 32'(H_TOTAL - 1));
  assign v_last = (vx == 32'(V_TOTAL - 1));

  // Raster counters: horizontal wraps, vertical steps on each wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) v_cnt <= '0;
        else        v_cnt <= v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Scale mode is latched only at the frame wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      scale_q <= 1'b0;
    else if (en && h_last && v_last)
      scale_q <= scale;
  end

  // Stage 0: visibility, sync levels and framebuffer address.
  always_comb begin
    act0   = (hx < H_ACT) && (vx < V_ACT);
    hs0    = (hx >= HS_BEG && hx < HS_END) ? HS_POL : ~HS_POL;
    vs0    = (vx >= VS_BEG && vx < VS_END) ? VS_POL : ~VS_POL;
    hx_s   = scale_q ? (hx >> 1) : hx;
    vx_s   = scale_q ? (vx >> 1) : vx;
    h_addr = act0 ? hx_s[9:0] : 10'd0;
    v_addr = act0 ? vx_s[9:0] : 10'd0;
  end

  // Strobes are masked by resetn so they drop as soon as reset asserts.
  always_comb begin
    rd_en       = act0 && en && resetn;
    frame_start = en && resetn && (hx == 32'd0) && (vx == 32'd0);
    line_start  = en && resetn && (hx == 32'd0) && (vx < V_ACT);
  end

  // Delay sync and blank to match memory latency plus colour register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs_p  <= {(RD_LAT+1){~HS_POL}};
      vs_p  <= {(RD_LAT+1){~VS_POL}};
      act_p <= '0;
    end else if (en) begin
      hs_p[0]  <= hs0;
      vs_p[0]  <= vs0;
      act_p[0] <= act0;
      for (int i = 1; i <= RD_LAT; i++) begin
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        act_p[i] <= act_p[i-1];
      end
    end
  end

  if (RD_LAT == 0) begin : g_lat0
    assign act_mem = act0;
  end else begin : g_latn
    assign act_mem = act_p[RD_LAT-1];
  end

  // Colour register: memory data when the matching pixel is visible.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (en) begin
      if (act_mem) begin
        vga_r <= rd_data[3*COLOR_W-1:2*COLOR_W];
        vga_g <= rd_data[2*COLOR_W-1:COLOR_W];
        vga_b <= rd_data[COLOR_W-1:0];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  assign hsync = hs_p[RD_LAT];
  assign vsync = vs_p[RD_LAT];
  assign valid = act_p[RD_LAT];

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL expose parameters, one per line as name, default, meaning:
  H_ACTIVE 640 visible pixels per line; H_FP 16; H_SYNC 96; H_BP 48 (horizontal porches/sync, in pixels)
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (vertical porches/sync, in lines)
  HS_POL 0, VS_POL 0: sync active level (0 = active-low)
  RD_LAT 1: pixel-memory read latency in enabled cycles, legal 0..4
  COLOR_W 8: bits per colour channel
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning. There is one clock; reset is asynchronous and active-low.
  clock  in  1  pixel-domain clock
  resetn  in  1  asynchronous active-low reset
  en  in  1  pixel clock enable; all state advances only when en=1
  scale  in  1  0 = native addressing, 1 = 2x pixel/line doubling
  h_addr  out  10  framebuffer column
  v_addr  out  10  framebuffer row
  rd_en  out  1  memory read strobe
  rd_data  in  3*COLOR_W  {R,G,B} returned RD_LAT enabled cycles after rd_en
  hsync, vsync  out  1  sync outputs, polarity per HS_POL/VS_POL
  valid  out  1  visible-pixel flag (blank_n)
  vga_r, vga_g, vga_b  out  COLOR_W  colour outputs
  frame_start  out  1  one-clock pulse at the first pixel of a frame
  line_start  out  1  one-clock pulse at the first pixel of each line

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters) in the order active, FP, sync, BP; on wrap, v_cnt SHALL increment over 0..V_TOTAL-1 in the same order.
REQ-004 Counters and pipeline SHALL hold when en=0; wrap-around SHALL occur only on an enabled cycle.
REQ-005 Stage 0: act0 = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); rd_en = act0&&en.
REQ-006 h_addr/v_addr SHALL be h_cnt/v_cnt (scale_q=0) or h_cnt>>1/v_cnt>>1 (scale_q=1) when act0=1, and 0 otherwise.
REQ-007 scale SHALL be sampled into scale_q only on the enabled cycle where h_cnt and v_cnt both wrap to 0; mid-frame changes SHALL have no effect until the next frame.
REQ-008 The hsync, vsync and act0 derived from the counters SHALL pass through a shift pipeline of RD_LAT+1 enabled stages, so that hsync, vsync, valid and RGB are mutually aligned.
REQ-009 vga_r/g/b SHALL be registered: rd_data fields when the aligned valid=1, else 0; RD_LAT=0 SHALL support purely combinational memory.
REQ-010 hsync SHALL be at level HS_POL for exactly H_SYNC enabled cycles per line; vsync at VS_POL for exactly V_SYNC lines, with changes aligned to the hsync line boundary (h_cnt=0).
REQ-011 frame_start SHALL be high for one clock when en=1 and h_cnt=v_cnt=0; line_start SHALL be high for one clock when en=1 and h_cnt=0 and v_cnt<V_ACTIVE; both SHALL be aligned with stage 0 (addresses).
REQ-012 Parameters with RD_LAT>4, H_ACTIVE>1024 or V_ACTIVE>1024 SHALL cause an elaboration error.

Reset
REQ-013 resetn=0 SHALL asynchronously force: h_cnt=v_cnt=0, pipeline cleared, hsync=~HS_POL, vsync=~VS_POL, valid=0, RGB=0, rd_en=0, frame_start=line_start=0, scale_q=0.
REQ-014 After resetn rises, the first enabled cycle SHALL present h_addr=0/v_addr=0 with frame_start=1.

Verification
REQ-015 Defaults, en=1: first valid=1 exactly 2 clocks after frame_start; valid high for 640 clocks per line on 480 lines; frame_start period = 420000 clocks.
REQ-016 Defaults: hsync low for 96 clocks, starting at clock 658 of each line (counted from line_start); vsync low for lines 490-491; polarity inverted when HS_POL=VS_POL=1.
REQ-017 RD_LAT=3, model memory returning {h,v}-derived colour: output pixel N matches address N issued 4 clocks earlier; RGB=0 in blanking.
REQ-018 scale raised mid-frame -> native addressing for the rest of that frame; next frame: h_addr 0,0,1,1..319,319; v_addr 0 for lines 0-1, 1 for lines 2-3.
REQ-019 en toggling 1,0,1,0 -> outputs hold on en=0 cycles; line period = 1600 clocks; no duplicated or skipped pixels.
REQ-020 resetn pulsed low mid-line (h_cnt=300) without a clock edge -> outputs go to their reset values immediately; after release the sequence restarts per REQ-014.
